imem_unit: RTL and testbench

IMEM_UNIT -- requirements
Module: imem_unit

---
 rtl/lc3b_pkg.sv | 12 +
 rtl/imem_array.sv | 66 ++++++
 rtl/imem_unit.sv | 81 ++++++++
 tb/tb_imem_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/lc3b_pkg.sv
// lc3b_pkg: shared fetch-unit state encoding and machine word width
package lc3b_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        RESP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/imem_array.sv
// imem_array: instruction storage with one write port and one combinational read port.
// Macro IMEM_ICACHE_EN selects an NLINES direct-mapped cache; otherwise a single last-fill entry.
module imem_array
    import lc3b_pkg::*;
#(
    parameter int NLINES = 8,
    parameter int IDXW   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [14:0]       waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [14:0]       raddr_i,
    output logic              hit_o,
    output logic [WORD_W-1:0] rdata_o
);

    if (NLINES != (1 << IDXW)) begin : g_bad_cfg
        $error("imem_array: IDXW must equal log2(NLINES)");
    end

`ifdef IMEM_ICACHE_EN
    localparam int TAGW = 15 - IDXW;

    logic [NLINES-1:0] valid_q;
    logic [TAGW-1:0]   tag_q  [NLINES];
    logic [WORD_W-1:0] data_q [NLINES];
    logic [IDXW-1:0]   widx;
    logic [IDXW-1:0]   ridx;

    assign widx = waddr_i[IDXW-1:0];
    assign ridx = raddr_i[IDXW-1:0];

    // A fill overwrites whatever line sits at the index; reset only invalidates
    always_ff @(posedge clk) begin
        if (reset) valid_q <= '0;
        else if (we_i) valid_q[widx] <= 1'b1;
        if (we_i && !reset) begin
            tag_q[widx]  <= waddr_i[14:IDXW];
            data_q[widx] <= wdata_i;
        end
    end

    assign hit_o   = valid_q[ridx] && (tag_q[ridx] == raddr_i[14:IDXW]);
    assign rdata_o = data_q[ridx];
`else
    logic              valid_q;
    logic [14:0]       addr_q;
    logic [WORD_W-1:0] data_q;

    // Remember only the most recent fill, keyed by its full word address
    always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else if (we_i) begin
            valid_q <= 1'b1;
            addr_q  <= waddr_i;
            data_q  <= wdata_i;
        end
    end

    assign hit_o   = valid_q && (addr_q == raddr_i);
    assign rdata_o = data_q;
`endif

endmodule

// File: rtl/imem_unit.sv
// imem_unit: instruction fetch front end with miss FSM and registered memory handshake.
// Macro IMEM_ICACHE_EN enables the NLINES direct-mapped cache in imem_array.
module imem_unit
    import lc3b_pkg::*;
#(
    parameter int NLINES = 8,
    parameter int IDXW   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       pc,
    output logic              imem_r,
    output logic [WORD_W-1:0] instr,
    output logic              mem_req,
    output logic [15:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata
);

    fetch_state_e      state_q, state_d;
    logic [14:0]       fa_q, fa_d;
    logic              mem_req_q, mem_req_d;
    logic [15:0]       mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] word_q;
    logic              hit;
    logic [WORD_W-1:0] arr_rdata;
    logic              fill;
    logic              unused_pc0;

    assign unused_pc0 = pc[0];
    assign fill       = (state_q == MISS) && mem_ack && !reset;

    imem_array #(
        .NLINES(NLINES),
        .IDXW  (IDXW)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .we_i   (fill),
        .waddr_i(fa_q),
        .wdata_i(mem_rdata),
        .raddr_i(pc[15:1]),
        .hit_o  (hit),
        .rdata_o(arr_rdata)
    );

    // State, fetch address and the registered memory request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fa_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fa_q       <= fa_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
        if (fill) word_q <= mem_rdata;
    end

    // Next state: misses wait in MISS for the ack, RESP always lasts one cycle
    always_comb begin
        state_d    = state_q == IDLE ? (hit ? IDLE : MISS)
                   : state_q == MISS ? (mem_ack ? RESP : MISS) : IDLE;
        fa_d       = (state_q == IDLE && !hit) ? pc[15:1] : fa_q;
        mem_req_d  = state_d == MISS;
        mem_addr_d = mem_req_d ? {fa_d, 1'b0} : mem_addr_q;
    end

    // Outputs: hits answer in IDLE, the fill word answers in RESP only if pc still matches
    always_comb begin
        imem_r = state_q == IDLE ? hit : (state_q == RESP && pc[15:1] == fa_q);
        instr  = !imem_r ? '0 : state_q == RESP ? word_q : arr_rdata;
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_imem_unit.sv
// tb_imem_unit: scoreboard bench for imem_unit against a line-table reference model
module tb_imem_unit;

    localparam int NLINES = 8;
    localparam int IDXW   = 3;

    typedef struct {
        logic        r;
        logic [15:0] ins;
        logic        req;
        logic [15:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc = '0;
    logic        imem_r;
    logic [15:0] instr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    // Reference model: a table of filled lines plus the outstanding-miss bookkeeping
    logic        vm [NLINES];
    logic [14:0] am [NLINES];
    logic [15:0] wm [NLINES];
    logic        m_busy = 1'b0;
    logic        m_resp = 1'b0;
    logic [14:0] m_fa = '0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_word = '0;

    imem_unit #(.NLINES(NLINES), .IDXW(IDXW)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .imem_r   (imem_r),
        .instr    (instr),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic int line_of(logic [14:0] w);
`ifdef IMEM_ICACHE_EN
        return int'(w) % NLINES;
`else
        return 0;
`endif
    endfunction

    task automatic cmp(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cycle(logic [15:0] p, logic a, logic [15:0] d, logic r, bit chk);
        exp_t e;
        int   l;
        logic h;
        @(negedge clk);
        pc = p; mem_ack = a; mem_rdata = d; reset = r;
        l = line_of(p[15:1]);
        h = vm[l] && am[l] == p[15:1];
        e.req  = m_busy;
        e.addr = m_addr;
        if (m_resp) e.r = p[15:1] == m_fa;
        else e.r = !m_busy && h;
        e.ins = !e.r ? 16'h0000 : m_resp ? m_word : wm[l];
        if (chk) sb.push_back(e);
        if (r) begin
            m_busy = 0; m_resp = 0; m_fa = '0; m_addr = '0;
            foreach (vm[i]) vm[i] = 1'b0;
        end else if (m_resp) m_resp = 0;
        else if (m_busy) begin
            if (a) begin
                l = line_of(m_fa);
                vm[l] = 1'b1; am[l] = m_fa; wm[l] = d;
                m_word = d; m_resp = 1; m_busy = 0;
            end
        end else if (!h) begin
            m_busy = 1; m_fa = p[15:1]; m_addr = {p[15:1], 1'b0};
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                cmp("imem_r", {15'd0, imem_r}, {15'd0, e.r});
                cmp("instr", instr, e.ins);
                cmp("mem_req", {15'd0, mem_req}, {15'd0, e.req});
                cmp("mem_addr", mem_addr, e.addr);
            end
        end
    end

    initial begin
        logic [15:0] p;
        foreach (vm[i]) vm[i] = 1'b0;
        cycle(16'h3000, 0, 0, 1, 0);
        cycle(16'h3000, 0, 0, 1, 1);
        cycle(16'h3000, 0, 0, 0, 1);
        // Cold miss: three MISS cycles, ack on the third, word returned next cycle
        cycle(16'h3000, 0, 16'h1234, 0, 1);
        cycle(16'h3000, 0, 16'h1234, 0, 1);
        cycle(16'h3000, 1, 16'h1234, 0, 1);
        repeat (3) cycle(16'h3000, 0, 0, 0, 1);
        cycle(16'h3001, 0, 0, 0, 1);
        // Same index, different tag evicts 3000
        cycle(16'h3010, 0, 0, 0, 1);
        cycle(16'h3010, 1, 16'h5678, 0, 1);
        repeat (2) cycle(16'h3010, 0, 0, 0, 1);
        cycle(16'h3000, 0, 0, 0, 1);
        cycle(16'h3000, 0, 0, 0, 1);
        cycle(16'h3000, 1, 16'h1234, 0, 1);
        repeat (2) cycle(16'h3000, 0, 0, 0, 1);
        // Redirect during MISS: fill completes but no stale response
        cycle(16'h5000, 0, 0, 0, 1);
        cycle(16'h4000, 0, 0, 0, 1);
        cycle(16'h4000, 1, 16'hAAAA, 0, 1);
        repeat (2) cycle(16'h4000, 0, 0, 0, 1);
        cycle(16'h4000, 1, 16'hBBBB, 0, 1);
        repeat (2) cycle(16'h4000, 0, 0, 0, 1);
        // Reset in MISS, late ack must not fill
        cycle(16'h6000, 0, 0, 0, 1);
        cycle(16'h6000, 0, 0, 1, 1);
        cycle(16'h6000, 1, 16'hDEAD, 0, 1);
        repeat (3) cycle(16'h6000, 0, 0, 0, 1);
        cycle(16'h6000, 1, 16'h0600, 0, 1);
        repeat (2) cycle(16'h6000, 0, 0, 0, 1);
        // Ack in IDLE is ignored
        cycle(16'h6000, 1, 16'hFFFF, 0, 1);
        repeat (2) cycle(16'h6000, 0, 0, 0, 1);
        repeat (600) begin
            p = $urandom_range(0, 7) == 0 ? 16'($urandom)
              : 16'h3000 | 16'($urandom_range(0, 31) << 1) | 16'($urandom_range(0, 1));
            cycle(p, $urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 99) == 0, 1);
        end
        repeat (5) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
